// File: rtl/mult_16_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
package mult_16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mult_16.sv
// Unsigned sequential shift-and-add multiplier, one partial product per clock.
//
// state  | meaning
// IDLE   | waiting for a rising edge on init_in
// CALC   | WIDTH add/shift iterations, then product hand-off
// DONE   | Result valid, done pulses for this single cycle
module mult_16
    import mult_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 done,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

    logic [1:0]           state_q,  state_d;
    logic                 init_q,   init_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic start;

    assign start = init_in && !init_q;

    always_comb begin
        state_d  = state_q;
        init_d   = init_in;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // All WIDTH iterations always run, so latency is operand-independent.
                if (cnt_q == LAST_ITER) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign Result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_16.sv
// Directed and randomised checks of mult_16 against an arithmetic reference product.
module tb_mult_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_in;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] Result;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_res;

    mult_16 dut (
        .clk     (clk),
        .rst     (rst),
        .init_in (init_in),
        .A       (A),
        .B       (B),
        .Result  (Result),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts an operation, holds init_in for `hold` edges, optionally fires a
    // second start with new operands `glitch` edges after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int hold, input int glitch, input string tag);
        logic [31:0] exp_res;
        int k;
        int busy_cnt;
        exp_res = 32'(a) * 32'(b);
        A = a;
        B = b;
        init_in = 1'b1;
        tick();
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        A = a ^ 16'h5a5a;
        B = b ^ 16'ha5a5;
        k = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && k < 40) begin
            init_in = (k + 1 < hold) || (k + 1 == glitch);
            if (k + 1 == glitch) begin
                A = 16'd7;
                B = 16'd9;
            end
            tick();
            k++;
            if (!done) begin
                busy_cnt += busy ? 1 : 0;
                check({tag, "_result_hold"}, 64'(Result), 64'(last_res));
            end
        end
        init_in = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'd17);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd17);
        check({tag, "_result"}, 64'(Result), 64'(exp_res));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        last_res = exp_res;
        tick();
        check({tag, "_done_width"}, 64'(done), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_result_after"}, 64'(Result), 64'(exp_res));
    endtask

    initial begin
        int extra_done;
        logic [15:0] ra;
        logic [15:0] rb;

        rst = 1'b1;
        init_in = 1'b1;
        A = 16'd3;
        B = 16'd4;
        last_res = 32'd0;
        tick();
        tick();
        check("reset_result", 64'(Result), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy_with_start", 64'(busy), 64'd0);
        init_in = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        run_op(16'd35, 16'd5, 2, -1, "35x5");
        run_op(16'hFFFF, 16'hFFFF, 1, -1, "max");
        run_op(16'd0, 16'd1234, 1, -1, "zero_a");
        run_op(16'd1234, 16'd0, 1, -1, "zero_b");

        // Restart request mid-operation must be dropped, not queued.
        run_op(16'd100, 16'd3, 1, 5, "ignored_start");
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            extra_done += done ? 1 : 0;
        end
        check("no_queued_done", 64'(extra_done), 64'd0);
        check("ignored_busy", 64'(busy), 64'd0);
        run_op(16'd7, 16'd9, 1, -1, "fresh_7x9");

        // Reset during CALC aborts without a done pulse.
        A = 16'd50;
        B = 16'd50;
        init_in = 1'b1;
        tick();
        init_in = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_result", 64'(Result), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        last_res = 32'd0;
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            extra_done += done ? 1 : 0;
        end
        check("abort_no_done", 64'(extra_done), 64'd0);

        // init_in already high when reset releases starts immediately.
        A = 16'd12;
        B = 16'd13;
        init_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_start", 64'(busy), 64'd1);
        extra_done = 0;
        while (!done && extra_done < 40) begin
            tick();
            extra_done++;
        end
        check("post_reset_latency", 64'(extra_done), 64'd17);
        check("post_reset_result", 64'(Result), 64'd156);
        init_in = 1'b0;
        tick();
        last_res = 32'd156;

        // Held-high init_in gives one operation only.
        A = 16'd11;
        B = 16'd11;
        init_in = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            extra_done += done ? 1 : 0;
        end
        check("held_init_single_op", 64'(extra_done), 64'd1);
        check("held_init_result", 64'(Result), 64'd121);
        last_res = 32'd121;
        init_in = 1'b0;
        tick();

        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            run_op(ra, rb, int'($urandom_range(1, 3)), -1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_16.md
MULT_16 -- requirements
Module: mult_16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; all widths below are given for the default.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port init_in, input, 1 bit: start request, acted on at its 0->1 transition.
REQ-005 The block SHALL have port A, input, 16 bits: unsigned multiplicand.
REQ-006 The block SHALL have port B, input, 16 bits: unsigned multiplier.
REQ-007 The block SHALL have port Result, output, 32 bits: unsigned product A*B.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.

Function
REQ-010 The block SHALL implement an unsigned sequential shift-and-add multiply with full 2*WIDTH-bit result, so no overflow or truncation is possible.
REQ-011 The block SHALL have states IDLE, CALC and DONE, all registered.
REQ-012 The block SHALL register init_in each cycle and detect a start as init_in=1 while the registered init_in=0.
REQ-013 In IDLE, on a start detected at edge N, the block SHALL latch A and B, clear the accumulator and the iteration count, and enter CALC.
REQ-014 In CALC, each clock SHALL perform one iteration: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1.
REQ-015 CALC SHALL run exactly WIDTH iterations, at edges N+1..N+16, with no early exit for zero operands.
REQ-016 At edge N+17 the block SHALL enter DONE, load Result with the product, and set done=1.
REQ-017 At edge N+18 the block SHALL return to IDLE and clear done, so done is high for exactly one clock.
REQ-018 Result SHALL hold its value from completion until the next completion; it SHALL NOT change during CALC.
REQ-019 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-020 Starts detected while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 init_in held high over many cycles SHALL produce exactly one operation.
REQ-022 A new operation SHALL require init_in to go low and then high again while the block is in IDLE.
REQ-023 A and B SHALL be sampled only at the start edge; later changes to A or B SHALL NOT affect the result in progress.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL enter IDLE and set Result=0, done=0, busy=0, accumulator=0, iteration count=0, and registered init_in=0.
REQ-025 rst SHALL take priority over every other condition, including a start in the same cycle.
REQ-026 rst asserted during CALC or DONE SHALL abort the operation with no done pulse.
REQ-027 After rst deasserts, init_in already high SHALL count as a start on the first non-reset edge.

Structure
REQ-028 A shared package SHALL hold the WIDTH default (16), the state encoding (IDLE, CALC, DONE), and the iteration-count width of 5 bits.
REQ-029 The block SHALL be a single module with no sub-module; the control FSM and the datapath are small enough to stay together.

Verification
REQ-030 Reset then A=35, B=5, init_in high for 2 cycles -> done pulses once, 17 cycles after the start edge, with Result=175 and busy high for 17 cycles.
REQ-031 A=16'hFFFF, B=16'hFFFF -> Result=32'hFFFE0001.
REQ-032 A=0, B=1234 and then A=1234, B=0 -> Result=0 each time, still after the full 17-cycle latency.
REQ-033 A second init_in pulse at cycle 5 of an operation, with A and B changed to 7 and 9 -> the first result is unchanged and no second done pulse occurs; a fresh start after done gives Result=63.
REQ-034 rst asserted at cycle 8 of an operation -> no done pulse, and Result, done and busy are all 0 on the next cycle.
REQ-035 Randomised back-to-back operations, at least 200 of them, checked against a reference model -> every Result matches and every done pulse is exactly 1 cycle wide.
